// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencing logic.
package hazard_pkg;

    localparam int HZ_REG_ADDR_WIDTH = 5;
    localparam logic [HZ_REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Load-use comparator: flags a decode instruction that reads the destination of a load in EX.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int W = HZ_REG_ADDR_WIDTH
) (
    input  logic         valid_if_id,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    input  logic         uses_rt,
    input  logic         mem_read,
    input  logic [W-1:0] rd,
    output logic         hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (rd == rs);
    assign rt_match = uses_rt & (rd == rt);

    // Writes to the zero register never produce a value, so they cannot create a dependency.
    assign hazard = valid_if_id & mem_read & (rd != W'(REG_ZERO)) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hold/bubble/flush sequencing for load-use, data-bus latency and taken branches.
//  state    | meaning
//  RUN      | normal flow; branch flush and load-use stall evaluated here
//  MEM_WAIT | data bus request outstanding; pipeline frozen until response
//  ERROR    | bus response never arrived; frozen until reset
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT    = 256,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      inValidIfId,
    input  logic [REG_ADDR_WIDTH-1:0] inRegisterRsIfId,
    input  logic [REG_ADDR_WIDTH-1:0] inRegisterRtIfId,
    input  logic                      inUsesRtIfId,
    input  logic                      inMemReadIdEx,
    input  logic [REG_ADDR_WIDTH-1:0] inRegisterRdIdEx,
    input  logic                      inBranchTakenEx,
    input  logic                      inMemReqExMem,
    input  logic                      inMemRespValid,
    output logic                      outStallPc,
    output logic                      outStallIfId,
    output logic                      outStallIdEx,
    output logic                      outStallExMem,
    output logic                      outBubbleIdEx,
    output logic                      outBubbleMemWb,
    output logic                      outFlushIfId,
    output logic                      outFlushIdEx,
    output logic                      outMemTimeout,
    output logic [CNT_WIDTH-1:0]      outStallCycles
);

    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t            state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;

    logic hazard;
    logic freeze_raw;
    logic freeze;
    logic active;
    logic flush;
    logic lu_stall;

    load_use_detect #(
        .W (REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .valid_if_id (inValidIfId),
        .rs          (inRegisterRsIfId),
        .rt          (inRegisterRtIfId),
        .uses_rt     (inUsesRtIfId),
        .mem_read    (inMemReadIdEx),
        .rd          (inRegisterRdIdEx),
        .hazard      (hazard)
    );

    always_comb begin
        freeze_raw = 1'b0;
        unique case (state)
            RUN:      freeze_raw = inMemReqExMem & ~inMemRespValid;
            MEM_WAIT: freeze_raw = ~inMemRespValid;
            ERROR:    freeze_raw = 1'b1;
            default:  freeze_raw = 1'b1;
        endcase
    end

    // The response cycle out of MEM_WAIT behaves like RUN so held branch/load-use inputs act then.
    assign freeze   = reset_n & freeze_raw;
    assign active   = reset_n & ~freeze_raw;
    assign flush    = active & inBranchTakenEx;
    assign lu_stall = active & ~inBranchTakenEx & hazard;

    assign outStallPc     = freeze | lu_stall;
    assign outStallIfId   = freeze | lu_stall;
    assign outStallIdEx   = freeze;
    assign outStallExMem  = freeze;
    assign outBubbleIdEx  = lu_stall;
    assign outBubbleMemWb = freeze;
    assign outFlushIfId   = flush;
    assign outFlushIdEx   = flush;
    assign outMemTimeout  = mem_timeout;
    assign outStallCycles = stall_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (inMemReqExMem && !inMemRespValid) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (inMemRespValid) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_LAST) begin
                            state       <= ERROR;
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (outStallPc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: per-cycle expected controls via a scoreboard.
module tb_hazard_stall_controller;

    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] FRZ  = 8'b1111_0100;
    localparam logic [7:0] LU   = 8'b1100_1000;
    localparam logic [7:0] FL   = 8'b0000_0011;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       resp;
        logic [7:0] ctl;
        logic       tmo;
    } step_t;

    typedef struct {
        logic [7:0] ctl;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       valid, uses_rt, mem_read, br, req, resp;
    logic [4:0] rs, rt, rd;

    logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic       bubble_idex, bubble_memwb, flush_ifid, flush_idex, mem_timeout;
    logic [31:0] stall_cycles;

    logic       s_stall_pc, s_stall_ifid, s_stall_idex, s_stall_exmem;
    logic       s_bubble_idex, s_bubble_memwb, s_flush_ifid, s_flush_idex, s_mem_timeout;
    logic [2:0] s_stall_cycles;

    logic [7:0] obs_ctl;
    assign obs_ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                      bubble_idex, bubble_memwb, flush_ifid, flush_idex};

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_cnt;
    exp_t sb[$];

    hazard_stall_controller #(.MEM_TIMEOUT(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .inValidIfId(valid), .inRegisterRsIfId(rs), .inRegisterRtIfId(rt),
        .inUsesRtIfId(uses_rt), .inMemReadIdEx(mem_read), .inRegisterRdIdEx(rd),
        .inBranchTakenEx(br), .inMemReqExMem(req), .inMemRespValid(resp),
        .outStallPc(stall_pc), .outStallIfId(stall_ifid), .outStallIdEx(stall_idex),
        .outStallExMem(stall_exmem), .outBubbleIdEx(bubble_idex), .outBubbleMemWb(bubble_memwb),
        .outFlushIfId(flush_ifid), .outFlushIdEx(flush_idex),
        .outMemTimeout(mem_timeout), .outStallCycles(stall_cycles)
    );

    hazard_stall_controller #(.MEM_TIMEOUT(16), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .reset_n(reset_n),
        .inValidIfId(valid), .inRegisterRsIfId(rs), .inRegisterRtIfId(rt),
        .inUsesRtIfId(uses_rt), .inMemReadIdEx(mem_read), .inRegisterRdIdEx(rd),
        .inBranchTakenEx(br), .inMemReqExMem(req), .inMemRespValid(resp),
        .outStallPc(s_stall_pc), .outStallIfId(s_stall_ifid), .outStallIdEx(s_stall_idex),
        .outStallExMem(s_stall_exmem), .outBubbleIdEx(s_bubble_idex), .outBubbleMemWb(s_bubble_memwb),
        .outFlushIfId(s_flush_ifid), .outFlushIdEx(s_flush_idex),
        .outMemTimeout(s_mem_timeout), .outStallCycles(s_stall_cycles)
    );

    function automatic step_t st(logic v, logic [4:0] s_rs, logic [4:0] s_rt, logic u,
                                 logic mr, logic [4:0] s_rd, logic b, logic rq, logic rp,
                                 logic [7:0] c, logic t);
        step_t s;
        s.valid = v;  s.rs = s_rs; s.rt = s_rt; s.uses_rt = u; s.mem_read = mr;
        s.rd = s_rd;  s.br = b;    s.req = rq;  s.resp = rp;   s.ctl = c; s.tmo = t;
        return s;
    endfunction

    task automatic clear_inputs();
        valid = 0; rs = 0; rt = 0; uses_rt = 0; mem_read = 0; rd = 0; br = 0; req = 0; resp = 0;
    endtask

    task automatic apply(input step_t s);
        @(posedge clk);
        #1;
        valid = s.valid; rs = s.rs; rt = s.rt; uses_rt = s.uses_rt; mem_read = s.mem_read;
        rd = s.rd; br = s.br; req = s.req; resp = s.resp;
        sb.push_back('{ctl: s.ctl, tmo: s.tmo});
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 0;
        exp_cnt = 0;
        sb.delete();
        #3 reset_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req = 1;
        reset_n = 0;
        exp_cnt = 0;
        #12;
        checks++;
        if (obs_ctl !== NONE || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold ctl=%b exp=%b tmo=%b cnt=%0d", obs_ctl, NONE, mem_timeout, stall_cycles);
        end
        clear_inputs();
        @(negedge clk);
        #3 reset_n = 1;
        begin
            exp_t e;
            apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL reset_idle ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
        end
    endtask

    task automatic test_no_hazard();
        step_t steps[$];
        exp_t e;
        steps.push_back(st(1, 0, 3, 1, 1, 0, 0, 0, 0, NONE, 0));
        steps.push_back(st(1, 2, 7, 0, 1, 7, 0, 0, 0, NONE, 0));
        steps.push_back(st(0, 5, 7, 1, 1, 5, 0, 0, 0, NONE, 0));
        steps.push_back(st(1, 5, 7, 1, 0, 5, 0, 0, 0, NONE, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL no_hazard[%0d] ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         i, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (e.ctl[7]) exp_cnt++;
        end
    endtask

    task automatic test_load_use();
        step_t steps[$];
        exp_t e;
        steps.push_back(st(1, 5, 7, 1, 1, 5, 0, 0, 0, LU,   0));
        steps.push_back(st(1, 5, 7, 1, 0, 0, 0, 0, 0, NONE, 0));
        steps.push_back(st(1, 3, 9, 1, 1, 9, 0, 0, 0, LU,   0));
        steps.push_back(st(1, 3, 9, 1, 0, 0, 0, 0, 0, NONE, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL load_use[%0d] ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         i, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (e.ctl[7]) exp_cnt++;
        end
    endtask

    task automatic test_mem_wait();
        step_t steps[$];
        exp_t e;
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL mem_wait[%0d] ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         i, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (e.ctl[7]) exp_cnt++;
        end
    endtask

    task automatic test_priority();
        step_t steps[$];
        exp_t e;
        steps.push_back(st(1, 5, 7, 1, 1, 5, 1, 0, 0, FL,   0));
        steps.push_back(st(1, 5, 7, 1, 1, 5, 1, 1, 0, FRZ,  0));
        steps.push_back(st(1, 5, 7, 1, 1, 5, 1, 1, 0, FRZ,  0));
        steps.push_back(st(1, 5, 7, 1, 1, 5, 1, 1, 1, FL,   0));
        steps.push_back(st(1, 4, 6, 1, 1, 6, 0, 1, 0, FRZ,  0));
        steps.push_back(st(1, 4, 6, 1, 1, 6, 0, 1, 1, LU,   0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL priority[%0d] ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         i, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (e.ctl[7]) exp_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        step_t steps[$];
        exp_t e;
        // lw r4; lw r6,(r4); add r8,r6,r6 -- one stall per load
        steps.push_back(st(1, 4, 0, 0, 1, 4, 0, 0, 0, LU,   0));
        steps.push_back(st(1, 4, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        steps.push_back(st(1, 6, 6, 1, 1, 6, 0, 0, 0, LU,   0));
        steps.push_back(st(1, 6, 6, 1, 0, 0, 0, 0, 0, NONE, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL back_to_back[%0d] ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         i, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (e.ctl[7]) exp_cnt++;
        end
    endtask

    task automatic test_timeout_and_reset();
        step_t steps[$];
        exp_t e;
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1));
        steps.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 1));
        steps.push_back(st(1, 5, 7, 1, 1, 5, 1, 0, 1, FRZ, 1));
        foreach (steps[i]) begin
            apply(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL timeout[%0d] ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         i, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (e.ctl[7]) exp_cnt++;
        end
        // asynchronous reset out of ERROR with the freeze-causing inputs still applied
        #2 reset_n = 0;
        exp_cnt = 0;
        #1;
        checks++;
        if (obs_ctl !== NONE || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_from_error ctl=%b exp=%b tmo=%b cnt=%0d", obs_ctl, NONE, mem_timeout, stall_cycles);
        end
        clear_inputs();
        #1 reset_n = 1;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
            failures++;
            $display("FAIL after_error_reset ctl=%b exp=%b tmo=%b cnt=%0d", obs_ctl, e.ctl, mem_timeout, stall_cycles);
        end
        // asynchronous reset in the middle of MEM_WAIT
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
        sb.delete();
        #3 reset_n = 0;
        exp_cnt = 0;
        #1;
        checks++;
        if (obs_ctl !== NONE || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_wait ctl=%b exp=%b tmo=%b cnt=%0d", obs_ctl, NONE, mem_timeout, stall_cycles);
        end
        clear_inputs();
        #1 reset_n = 1;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs_ctl !== e.ctl || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
            failures++;
            $display("FAIL after_wait_reset ctl=%b exp=%b tmo=%b cnt=%0d", obs_ctl, e.ctl, mem_timeout, stall_cycles);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [2:0] sat_exp;
        do_reset();
        sat_exp = 0;
        for (int k = 1; k <= 10; k++) begin
            apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, (k >= 5)));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (s_stall_cycles !== sat_exp || s_stall_pc !== 1'b1 || obs_ctl !== e.ctl
                || mem_timeout !== e.tmo || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL saturation[%0d] sat_cnt=%0d exp=%0d ctl=%b exp=%b tmo=%b exp=%b cnt=%0d exp=%0d",
                         k, s_stall_cycles, sat_exp, obs_ctl, e.ctl, mem_timeout, e.tmo, stall_cycles, exp_cnt);
            end
            if (sat_exp != 3'd7) sat_exp++;
            if (e.ctl[7]) exp_cnt++;
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset_n = 1;
        exp_cnt = 0;
        test_reset();
        test_no_hazard();
        test_load_use();
        test_mem_wait();
        test_priority();
        test_back_to_back();
        test_timeout_and_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing block for the 5-stage integer core; pairs with the EX-stage forwarding unit.
- Covers hazards forwarding cannot resolve: load-use, data-memory bus latency and taken-branch squash.
- Drives PC/IF-ID/ID-EX/EX-MEM hold, bubble and flush controls from one FSM.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout error for debug.

Parameters:
- REG_ADDR_WIDTH, 5, width of register specifiers.
- MEM_TIMEOUT, 256, maximum cycles in MEM_WAIT before error; legal range 2..65535.
- CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- inValidIfId  in  1  IF/ID holds a valid instruction.
- inRegisterRsIfId  in  REG_ADDR_WIDTH  rs of instruction in decode.
- inRegisterRtIfId  in  REG_ADDR_WIDTH  rt of instruction in decode.
- inUsesRtIfId  in  1  decode instruction reads rt (0 for immediate forms).
- inMemReadIdEx  in  1  instruction in ID/EX is a load.
- inRegisterRdIdEx  in  REG_ADDR_WIDTH  destination of instruction in ID/EX.
- inBranchTakenEx  in  1  branch/jump resolved taken in EX this cycle.
- inMemReqExMem  in  1  MEM stage issues a data bus request this cycle.
- inMemRespValid  in  1  data bus response/ack this cycle.
- outStallPc  out  1  hold PC.
- outStallIfId  out  1  hold IF/ID.
- outStallIdEx  out  1  hold ID/EX.
- outStallExMem  out  1  hold EX/MEM.
- outBubbleIdEx  out  1  load NOP into ID/EX.
- outBubbleMemWb  out  1  load NOP into MEM/WB.
- outFlushIfId  out  1  squash IF/ID.
- outFlushIdEx  out  1  squash ID/EX.
- outMemTimeout  out  1  sticky bus-timeout error.
- outStallCycles  out  CNT_WIDTH  saturating count of cycles with outStallPc=1.

Behaviour:
- FSM states RUN, MEM_WAIT, ERROR. Reset: state RUN; wait counter 0; outStallCycles 0; outMemTimeout 0.
- Control outputs are combinational from state and inputs (same-cycle effect). All are 0 in reset and in RUN with no event.
- Memory freeze: asserts outStallPc, outStallIfId, outStallIdEx, outStallExMem and outBubbleMemWb.
- Memory freeze triggers:
  - RUN with inMemReqExMem=1 and inMemRespValid=0: freeze this cycle; next state MEM_WAIT; wait counter := 1.
  - RUN with request and response in the same cycle: no freeze; stay RUN.
- MEM_WAIT:
  - inMemRespValid=0: freeze; wait counter +1.
  - inMemRespValid=1: no freeze this cycle; next RUN; counter := 0.
  - Counter reaches MEM_TIMEOUT with no response: next ERROR; outMemTimeout := 1.
- ERROR: freeze held permanently; only reset exits. outMemTimeout stays 1.
- Priority within a cycle: memory freeze > branch flush > load-use stall.
  - Lower-priority events are ignored that cycle. Their inputs are held by the freeze and re-evaluated on resume.
- Branch flush (RUN, no freeze, inBranchTakenEx=1): assert outFlushIfId and outFlushIdEx for that cycle; no stall. A load-use hazard in the same cycle is suppressed.
- Load-use hazard (RUN, no freeze, no flush) when all hold:
  - inValidIfId=1, inMemReadIdEx=1, inRegisterRdIdEx≠0;
  - and rd==rs, or (inUsesRtIfId=1 and rd==rt).
  - Response: assert outStallPc, outStallIfId, outBubbleIdEx.
- Load-use repeats: exactly one cycle per load, because the next ID/EX holds the bubble. Back-to-back loads into a dependent consumer produce one stall per load.
- outStallCycles: +1 each cycle outStallPc=1; saturates at all-ones; no wrap.
- Reset assertion mid-MEM_WAIT or in ERROR: asynchronous return to RUN; all counters and flags cleared immediately.

Decomposition:
- Shared package hazard_pkg:
  - enum of FSM states (RUN, MEM_WAIT, ERROR);
  - register-address width constant;
  - REG_ZERO constant.
- One natural sub-module: load_use_detect (pure combinational comparator producing the hazard flag), reused later by the decode-stage interlock. Everything else stays inline.

Test Plan:
- Load-use: lw rd=5, then add rs=5 rt=7 valid → one cycle of outStallPc/outStallIfId/outBubbleIdEx=1; next cycle all 0; outStallCycles=1.
- rd=0 load with consumer rs=0, and rt match with inUsesRtIfId=0 → no stall; outStallCycles stays 0.
- Memory wait: inMemReqExMem=1, response 3 cycles later → freeze outputs 1 for exactly 3 cycles, 0 on response cycle; outStallCycles=3. Same-cycle request+response → no freeze.
- Simultaneous events: taken branch plus load-use hazard → outFlushIfId=outFlushIdEx=1, no stall. Branch during MEM_WAIT → no flush until response cycle, then flush.
- Timeout with MEM_TIMEOUT=4, no response → ERROR after 4 wait cycles; outMemTimeout=1 and freeze held.
- Reset mid-MEM_WAIT and from ERROR → RUN, outputs 0, outStallCycles=0; force counter near all-ones → saturates, no wrap.
